// File: rtl/rv32i_hazard_unit.sv
// Scoreboard-based hazard detection and operand forwarding for the RV32I pipeline.
// Optional performance counters are enabled with `define RV32I_HAZ_PERF_CNT_EN.
module rv32i_hazard_unit #(
    parameter int XLEN       = 32,
    parameter int NSRC       = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int SELW       = $clog2(DEPTH + 2)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   id_valid,
    input  logic [NSRC*5-1:0]      id_rs,
    input  logic [NSRC-1:0]        id_rs_used,
    input  logic [4:0]             id_rd,
    input  logic                   id_regwrite,
    input  logic                   id_memtoreg,
    input  logic                   flush,
    input  logic [DEPTH*XLEN-1:0]  st_data,
    input  logic [NSRC*XLEN-1:0]   exe_rf_data,
    output logic                   stall,
    output logic [NSRC*XLEN-1:0]   exe_op,
    output logic [NSRC*SELW-1:0]   exe_fwd_sel,
    output logic [31:0]            stall_cnt,
    output logic [31:0]            fwd_cnt
);

    logic [DEPTH-1:0] sb_valid_q;
    logic [DEPTH-1:0] sb_wr_q;
    logic [DEPTH-1:0] sb_ld_q;
    logic [4:0]       sb_rd_q [DEPTH];

    logic [NSRC-1:0]  hazard;
    logic [SELW-1:0]  sel_d [NSRC];
    logic [SELW-1:0]  sel_q [NSRC];
    logic [XLEN-1:0]  retire_q;
    logic             issue;
    logic             load_sel;

    // EXE has no result yet, so stage 0 data is never a forwarding source.
    logic unused_st0;
    assign unused_st0 = ^st_data[XLEN-1:0];

    assign load_sel = ~stall & ~flush;
    assign issue    = id_valid & load_sel;
    assign stall    = (|hazard) & id_valid & ~flush;

    // Scanning oldest to youngest lets the youngest producer overwrite older matches.
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            hazard[i] = 1'b0;
            sel_d[i]  = '0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (id_rs_used[i] && (id_rs[5*i +: 5] != 5'd0) && sb_valid_q[k] &&
                    sb_wr_q[k] && (sb_rd_q[k] == id_rs[5*i +: 5])) begin
                    hazard[i] = (k + 1) < (sb_ld_q[k] ? LOAD_STAGE : 1);
                    sel_d[i]  = (k == DEPTH - 1) ? SELW'(DEPTH + 1) : SELW'(k + 1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sb_valid_q <= '0;
            sb_wr_q    <= '0;
            sb_ld_q    <= '0;
            for (int k = 0; k < DEPTH; k++) sb_rd_q[k] <= 5'd0;
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                sb_valid_q[k] <= sb_valid_q[k-1];
                sb_wr_q[k]    <= sb_wr_q[k-1];
                sb_ld_q[k]    <= sb_ld_q[k-1];
                sb_rd_q[k]    <= sb_rd_q[k-1];
            end
            sb_valid_q[0] <= issue;
            sb_wr_q[0]    <= issue & id_regwrite;
            sb_ld_q[0]    <= issue & id_memtoreg;
            sb_rd_q[0]    <= issue ? id_rd : 5'd0;
        end
    end

    // The retire latch stands in for the register file during the WB write cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            retire_q <= '0;
            for (int i = 0; i < NSRC; i++) sel_q[i] <= '0;
        end else begin
            retire_q <= st_data[(DEPTH-1)*XLEN +: XLEN];
            for (int i = 0; i < NSRC; i++) sel_q[i] <= load_sel ? sel_d[i] : '0;
        end
    end

    always_comb begin
        exe_op = exe_rf_data;
        for (int i = 0; i < NSRC; i++) begin
            for (int j = 1; j < DEPTH; j++) begin
                if (sel_q[i] == SELW'(j)) exe_op[i*XLEN +: XLEN] = st_data[j*XLEN +: XLEN];
            end
            if (sel_q[i] == SELW'(DEPTH + 1)) exe_op[i*XLEN +: XLEN] = retire_q;
        end
    end

    for (genvar g = 0; g < NSRC; g++) begin : g_sel_out
        assign exe_fwd_sel[g*SELW +: SELW] = sel_q[g];
    end

`ifdef RV32I_HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] fwd_cnt_q;
    logic [31:0] fwd_inc;

    always_comb begin
        fwd_inc = 32'd0;
        for (int i = 0; i < NSRC; i++) begin
            if (sel_d[i] != '0) fwd_inc = fwd_inc + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt_q <= 32'd0;
            fwd_cnt_q   <= 32'd0;
        end else begin
            if (stall)    stall_cnt_q <= stall_cnt_q + 32'd1;
            if (load_sel) fwd_cnt_q   <= fwd_cnt_q + fwd_inc;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`else
    assign stall_cnt = 32'd0;
    assign fwd_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_rv32i_hazard_unit.sv
// Directed self-checking bench for rv32i_hazard_unit with default parameters.
module tb_rv32i_hazard_unit;

    localparam int XLEN  = 32;
    localparam int NSRC  = 2;
    localparam int DEPTH = 3;
    localparam int SELW  = 3;

    localparam logic [31:0] RF0 = 32'hAAAA_0000;
    localparam logic [31:0] RF1 = 32'hBBBB_0001;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  id_valid;
    logic [NSRC*5-1:0]     id_rs;
    logic [NSRC-1:0]       id_rs_used;
    logic [4:0]            id_rd;
    logic                  id_regwrite;
    logic                  id_memtoreg;
    logic                  flush;
    logic [DEPTH*XLEN-1:0] st_data;
    logic [NSRC*XLEN-1:0]  exe_rf_data;
    logic                  stall;
    logic [NSRC*XLEN-1:0]  exe_op;
    logic [NSRC*SELW-1:0]  exe_fwd_sel;
    logic [31:0]           stall_cnt;
    logic [31:0]           fwd_cnt;

    int tests = 0;
    int fails = 0;

    rv32i_hazard_unit dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rs_used  (id_rs_used),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memtoreg (id_memtoreg),
        .flush       (flush),
        .st_data     (st_data),
        .exe_rf_data (exe_rf_data),
        .stall       (stall),
        .exe_op      (exe_op),
        .exe_fwd_sel (exe_fwd_sel),
        .stall_cnt   (stall_cnt),
        .fwd_cnt     (fwd_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [1:0] used, input logic [4:0] rd, input logic wr,
                         input logic ld);
        id_valid    = v;
        id_rs       = {r2, r1};
        id_rs_used  = used;
        id_rd       = rd;
        id_regwrite = wr;
        id_memtoreg = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        flush = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        repeat (DEPTH + 1) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0);
        repeat (2) tick();
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", stall); end
        tests++; if (exe_fwd_sel !== 6'd0) begin fails++; $display("FAIL reset_sel got %h want 0", exe_fwd_sel); end
        tests++; if (exe_op !== {RF1, RF0}) begin fails++; $display("FAIL reset_op got %h want %h", exe_op, {RF1, RF0}); end
        tests++; if (stall_cnt !== 32'd0 || fwd_cnt !== 32'd0) begin fails++; $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cnt, fwd_cnt); end
        reset_n = 1'b1;
        drain();
    endtask

    // add x5,x1,x2 ; sub x6,x5,x3
    task automatic test_alu_fwd();
        drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd3, 2'b11, 5'd6, 1'b1, 1'b0);
        st_data[1*XLEN +: XLEN] = 32'h0000_0010;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL alu_stall got %b want 0", stall); end
        tick();
        tests++; if (exe_fwd_sel !== {3'd0, 3'd1}) begin fails++; $display("FAIL alu_sel got %h want %h", exe_fwd_sel, {3'd0, 3'd1}); end
        tests++; if (exe_op !== {RF1, 32'h0000_0010}) begin fails++; $display("FAIL alu_op got %h want %h", exe_op, {RF1, 32'h0000_0010}); end
        drain();
    endtask

    // lw x7,0(x1) ; add x8,x7,x7
    task automatic test_load_use();
        drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd7, 5'd7, 2'b11, 5'd8, 1'b1, 1'b0);
        #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL lu_stall1 got %b want 1", stall); end
        tick();
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL lu_stall2 got %b want 0", stall); end
        tests++; if (exe_fwd_sel !== 6'd0) begin fails++; $display("FAIL lu_bubble_sel got %h want 0", exe_fwd_sel); end
        st_data[2*XLEN +: XLEN] = 32'hDEAD_BEEF;
        tick();
        tests++; if (exe_fwd_sel !== {3'd2, 3'd2}) begin fails++; $display("FAIL lu_sel got %h want %h", exe_fwd_sel, {3'd2, 3'd2}); end
        tests++; if (exe_op !== {32'hDEAD_BEEF, 32'hDEAD_BEEF}) begin fails++; $display("FAIL lu_op got %h want deadbeefdeadbeef", exe_op); end
        drain();
    endtask

    task automatic test_retire();
        drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd9, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd11, 5'd12, 2'b11, 5'd10, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd11, 5'd12, 2'b11, 5'd13, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd9, 5'd0, 2'b01, 5'd14, 1'b1, 1'b0);
        st_data[2*XLEN +: XLEN] = 32'h1234_5678;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL ret_stall got %b want 0", stall); end
        tick();
        st_data[2*XLEN +: XLEN] = 32'hFFFF_0000;
        #1;
        tests++; if (exe_fwd_sel !== {3'd0, 3'd4}) begin fails++; $display("FAIL ret_sel got %h want %h", exe_fwd_sel, {3'd0, 3'd4}); end
        tests++; if (exe_op[31:0] !== 32'h1234_5678) begin fails++; $display("FAIL ret_op got %h want 12345678", exe_op[31:0]); end
        drain();
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, 5'd0, 5'd0, 2'b01, 5'd4, 1'b1, 1'b0);
            tick();
        end
        drive(1'b1, 5'd4, 5'd0, 2'b11, 5'd15, 1'b1, 1'b0);
        st_data[1*XLEN +: XLEN] = 32'd3;
        st_data[2*XLEN +: XLEN] = 32'd2;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL b2b_stall got %b want 0", stall); end
        tick();
        tests++; if (exe_fwd_sel !== {3'd0, 3'd1}) begin fails++; $display("FAIL b2b_sel got %h want %h", exe_fwd_sel, {3'd0, 3'd1}); end
        tests++; if (exe_op !== {RF1, 32'd3}) begin fails++; $display("FAIL b2b_op got %h want %h", exe_op, {RF1, 32'd3}); end
        drain();
    endtask

    task automatic test_flush_x0();
        drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd7, 5'd7, 2'b11, 5'd8, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL fl_stall got %b want 0", stall); end
        tick();
        flush = 1'b0;
        tests++; if (exe_fwd_sel !== 6'd0) begin fails++; $display("FAIL fl_sel got %h want 0", exe_fwd_sel); end
        // The flushed add must not appear as a producer of x8.
        drive(1'b1, 5'd8, 5'd7, 2'b11, 5'd16, 1'b1, 1'b0);
        tick();
        tests++; if (exe_fwd_sel !== {3'd2, 3'd0}) begin fails++; $display("FAIL fl_bubble got %h want %h", exe_fwd_sel, {3'd2, 3'd0}); end
        drain();
        drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd0, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd0, 5'd0, 2'b11, 5'd17, 1'b1, 1'b0);
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL x0_stall got %b want 0", stall); end
        tick();
        tests++; if (exe_fwd_sel !== 6'd0) begin fails++; $display("FAIL x0_sel got %h want 0", exe_fwd_sel); end
        tests++; if (exe_op !== {RF1, RF0}) begin fails++; $display("FAIL x0_op got %h want %h", exe_op, {RF1, RF0}); end
        drain();
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd7, 5'd7, 2'b11, 5'd8, 1'b1, 1'b0);
        #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL rst_pre_stall got %b want 1", stall); end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rst_stall got %b want 0", stall); end
        tests++; if (exe_fwd_sel !== 6'd0) begin fails++; $display("FAIL rst_sel got %h want 0", exe_fwd_sel); end
        drain();
    endtask

    task automatic test_perf_cnt();
        logic [31:0] exp_stall;
        logic [31:0] exp_fwd;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int p = 0; p < 3; p++) begin
            drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1);
            tick();
            drive(1'b1, 5'd7, 5'd7, 2'b11, 5'd8, 1'b1, 1'b0);
            tick();
            tick();
        end
        drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
`ifdef RV32I_HAZ_PERF_CNT_EN
        exp_stall = 32'd3;
        exp_fwd   = 32'd6;
`else
        exp_stall = 32'd0;
        exp_fwd   = 32'd0;
`endif
        tests++; if (stall_cnt !== exp_stall) begin fails++; $display("FAIL perf_stall got %0d want %0d", stall_cnt, exp_stall); end
        tests++; if (fwd_cnt !== exp_fwd) begin fails++; $display("FAIL perf_fwd got %0d want %0d", fwd_cnt, exp_fwd); end
        drain();
    endtask

    initial begin
        reset_n     = 1'b0;
        flush       = 1'b0;
        st_data     = '0;
        exe_rf_data = {RF1, RF0};
        drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_retire();
        test_back_to_back();
        test_flush_x0();
        test_reset_mid_stall();
        test_perf_cnt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
